// File: rtl/divider_sequencer_pkg.sv
// Shared definitions for the repeated-subtraction divider sequencer.
// Holds the state encoding and the default counter width and limit.
package divider_sequencer_pkg;

    localparam int          ITER_W_DEF   = 32;
    localparam logic [31:0] MAX_ITER_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COMP   = 3'd2,
        S_DECIDE = 3'd3,
        S_SUB    = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/divider_sequencer_if.sv
// Bundles the controller handshake and the datapath strobes/status around the sequencer.
// The master side is the controller plus datapath; the slave side is the sequencer.
interface divider_sequencer_if
    import divider_sequencer_pkg::*;
#(
    parameter int ITER_W = ITER_W_DEF
);
    logic              Start;
    logic              Ack;
    logic              BZero;
    logic              CompOut;
    logic              Load;
    logic              CompEn;
    logic              SubEn;
    logic              CntEn;
    logic              Busy;
    logic              Done;
    logic              DivZero;
    logic              Overflow;
    logic [ITER_W-1:0] IterCount;

    modport master (
        output Start, Ack, BZero, CompOut,
        input  Load, CompEn, SubEn, CntEn, Busy, Done, DivZero, Overflow, IterCount
    );

    modport slave (
        input  Start, Ack, BZero, CompOut,
        output Load, CompEn, SubEn, CntEn, Busy, Done, DivZero, Overflow, IterCount
    );
endinterface

// File: rtl/divider_sequencer_iter_counter.sv
// Subtraction counter with synchronous clear, enable and terminal-count flag.
// Single-cycle update; terminal count is combinational from the registered count.
module divider_sequencer_iter_counter
    import divider_sequencer_pkg::*;
#(
    parameter int                ITER_W   = ITER_W_DEF,
    parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(MAX_ITER_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ITER_W-1:0] count,
    output logic              tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ITER_W'(1);
        end
    end

    // The sequencer never enables at terminal count, so count cannot wrap.
    assign tc = (count == MAX_ITER);

endmodule

// File: rtl/divider_sequencer.sv
// Moore FSM sequencing the repeated-subtraction divider: Load, then CompEn/Decide/Sub loops.
// Done after 3q+4 cycles from Start (1 for divide-by-zero); held until Ack, Start ignored meanwhile.
module divider_sequencer
    import divider_sequencer_pkg::*;
#(
    parameter int                ITER_W   = ITER_W_DEF,
    parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(MAX_ITER_DEF)
) (
    input  logic          CLK,
    input  logic          Reset,
    divider_sequencer_if.slave dif
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic              div_zero_q;
    logic              overflow_q;
    logic              iter_clr;
    logic              iter_tc;
    logic [ITER_W-1:0] iter_count;

    wire start_accept = (state_q == S_IDLE) && dif.Start;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dif.Load   = 1'b0;
        dif.CompEn = 1'b0;
        dif.SubEn  = 1'b0;
        dif.CntEn  = 1'b0;
        dif.Busy   = 1'b0;
        dif.Done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dif.Start) begin
                    state_d = dif.BZero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                dif.Load = 1'b1;
                dif.Busy = 1'b1;
                state_d  = S_COMP;
            end
            S_COMP: begin
                dif.CompEn = 1'b1;
                dif.Busy   = 1'b1;
                state_d    = S_DECIDE;
            end
            S_DECIDE: begin
                dif.Busy = 1'b1;
                // ALB wins over the limit: an exact MAX_ITER quotient is not an overflow.
                if (dif.CompOut || iter_tc) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                dif.SubEn = 1'b1;
                dif.CntEn = 1'b1;
                dif.Busy  = 1'b1;
                state_d   = S_COMP;
            end
            S_DONE: begin
                dif.Done = 1'b1;
                if (dif.Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags hold across DONE/IDLE and are only rewritten by an accepted Start.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (start_accept) begin
            div_zero_q <= dif.BZero;
            overflow_q <= 1'b0;
        end else if ((state_q == S_DECIDE) && !dif.CompOut && iter_tc) begin
            overflow_q <= 1'b1;
        end
    end

    assign iter_clr = start_accept || (state_q == S_LOAD);

    divider_sequencer_iter_counter #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk   (CLK),
        .rst   (Reset),
        .clr   (iter_clr),
        .en    (state_q == S_SUB),
        .count (iter_count),
        .tc    (iter_tc)
    );

    assign dif.DivZero   = div_zero_q;
    assign dif.Overflow  = overflow_q;
    assign dif.IterCount = iter_count;

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a behavioural divider datapath and a result scoreboard.
module tb_divider_sequencer;

    localparam int          ITER_W   = 32;
    localparam logic [31:0] MAX_ITER = 32'd4;

    typedef struct {
        int          q;
        bit          dz;
        bit          ov;
        int          done_edge;
        logic [31:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_sequencer_if #(.ITER_W(ITER_W)) dif ();

    divider_sequencer #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .dif   (dif.slave)
    );

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];
    exp_t last_exp;

    logic [31:0] dividend = '0;
    logic [31:0] divisor  = '0;
    logic [31:0] reg_a    = '0;
    logic        comp_q   = 1'b0;

    // Datapath: register A, registered comparator ALB.
    always @(posedge clk) begin
        if (dif.Load) begin
            reg_a <= dividend;
        end else if (dif.SubEn) begin
            reg_a <= reg_a - divisor;
        end
        if (rst) begin
            comp_q <= 1'b0;
        end else if (dif.CompEn) begin
            comp_q <= (reg_a < divisor);
        end
    end
    assign dif.CompOut = comp_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int load_cnt = 0;
    int comp_cnt = 0;
    int sub_cnt  = 0;
    int cnt_cnt  = 0;
    int load_base, comp_base, sub_base, cnt_base;

    always @(negedge clk) begin
        load_cnt += int'(dif.Load);
        comp_cnt += int'(dif.CompEn);
        sub_cnt  += int'(dif.SubEn);
        cnt_cnt  += int'(dif.CntEn);
        if (!rst) begin
            check("strobe_onehot", 32'(($countones({dif.Load, dif.CompEn, dif.SubEn}) <= 1)), 32'd1);
            check("busy_done_excl", 32'(dif.Busy & dif.Done), 32'd0);
        end
    end

    task automatic snap_counts();
        load_base = load_cnt;
        comp_base = comp_cnt;
        sub_base  = sub_cnt;
        cnt_base  = cnt_cnt;
    endtask

    task automatic push_exp(input logic [31:0] dd, input logic [31:0] dv);
        exp_t x;
        x.dz = (dv == 0);
        x.ov = 1'b0;
        x.q  = 0;
        if (!x.dz) begin
            x.q = int'(dd / dv);
            if (x.q > int'(MAX_ITER)) begin
                x.q  = int'(MAX_ITER);
                x.ov = 1'b1;
            end
        end
        x.done_edge = x.dz ? 1 : 3 * x.q + 4;
        x.rem       = x.dz ? 32'd0 : dd - 32'(x.q) * dv;
        sb.push_back(x);
    endtask

    // Called #1 after an edge: this cycle is cycle 0 with Start high.
    task automatic start_op(input logic [31:0] dd, input logic [31:0] dv);
        push_exp(dd, dv);
        dividend  = dd;
        divisor   = dv;
        dif.BZero = (dv == 0);
        dif.Start = 1'b1;
        snap_counts();
    endtask

    task automatic wait_done(input string tag, input bit release_start, input bit mid_ack);
        int   e;
        exp_t x;
        x = sb[0];
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
            if (release_start && e == 1) dif.Start = 1'b0;
            if (e == 1) dif.BZero = 1'b0;
            dif.Ack = mid_ack && (e == 2);
            if (e == 1 && !x.dz) begin
                check({tag, "_load_c1"}, 32'(dif.Load), 32'd1);
                check({tag, "_busy_c1"}, 32'(dif.Busy), 32'd1);
                check({tag, "_flags_clr"}, 32'({dif.DivZero, dif.Overflow}), 32'd0);
            end
        end while (!dif.Done && e < 400);
        dif.Ack = 1'b0;
        x = sb.pop_front();
        last_exp = x;
        check({tag, "_done_seen"}, 32'(dif.Done), 32'd1);
        check({tag, "_done_edge"}, 32'(e), 32'(x.done_edge));
        check({tag, "_iter"}, dif.IterCount, 32'(x.q));
        check({tag, "_divzero"}, 32'(dif.DivZero), 32'(x.dz));
        check({tag, "_overflow"}, 32'(dif.Overflow), 32'(x.ov));
        check({tag, "_busy"}, 32'(dif.Busy), 32'd0);
        check({tag, "_n_load"}, 32'(load_cnt - load_base), x.dz ? 32'd0 : 32'd1);
        check({tag, "_n_comp"}, 32'(comp_cnt - comp_base), x.dz ? 32'd0 : 32'(x.q + 1));
        check({tag, "_n_sub"}, 32'(sub_cnt - sub_base), 32'(x.q));
        check({tag, "_n_cnt"}, 32'(cnt_cnt - cnt_base), 32'(x.q));
        if (!x.dz) check({tag, "_remainder"}, reg_a, x.rem);
    endtask

    task automatic ack_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_held"}, 32'(dif.Done), 32'd1);
        dif.Ack = 1'b1;
        @(posedge clk);
        #1;
        dif.Ack = 1'b0;
        check({tag, "_ack_done"}, 32'(dif.Done), 32'd0);
        check({tag, "_ack_busy"}, 32'(dif.Busy), 32'd0);
        check({tag, "_hold_dz"}, 32'(dif.DivZero), 32'(last_exp.dz));
        check({tag, "_hold_ov"}, 32'(dif.Overflow), 32'(last_exp.ov));
        check({tag, "_hold_iter"}, dif.IterCount, 32'(last_exp.q));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 32'({dif.Load, dif.CompEn, dif.SubEn, dif.CntEn}), 32'd0);
        check({tag, "_busy_done"}, 32'({dif.Busy, dif.Done}), 32'd0);
        check({tag, "_flags"}, 32'({dif.DivZero, dif.Overflow}), 32'd0);
        check({tag, "_iter"}, dif.IterCount, 32'd0);
    endtask

    initial begin
        dif.Start = 1'b0;
        dif.Ack   = 1'b0;
        dif.BZero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("idle");

        start_op(32'd17, 32'd5);
        wait_done("d17_5", 1'b1, 1'b0);
        ack_op("d17_5");

        start_op(32'd3, 32'd7);
        wait_done("d3_7", 1'b1, 1'b0);
        ack_op("d3_7");

        start_op(32'd9, 32'd0);
        wait_done("d9_0", 1'b1, 1'b0);
        ack_op("d9_0");

        start_op(32'd7, 32'd7);
        wait_done("d7_7", 1'b1, 1'b0);
        ack_op("d7_7");

        start_op(32'd20, 32'd5);
        wait_done("d20_5", 1'b1, 1'b0);
        ack_op("d20_5");

        start_op(32'd100, 32'd1);
        wait_done("d100_1", 1'b1, 1'b0);
        ack_op("d100_1");

        // Reset landing while the FSM is in SUB.
        dividend  = 32'd17;
        divisor   = 32'd5;
        dif.Start = 1'b1;
        @(posedge clk);
        #1;
        dif.Start = 1'b0;
        for (int i = 0; i < 20 && !dif.SubEn; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_in_sub", 32'(dif.SubEn), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check("rst_mid_stays_idle", 32'({dif.Busy, dif.Load}), 32'd0);
        start_op(32'd17, 32'd5);
        wait_done("d17_5_post_rst", 1'b1, 1'b0);
        ack_op("d17_5_post_rst");

        // Reset while DONE with DivZero set clears the flag.
        start_op(32'd9, 32'd0);
        wait_done("d9_0_b", 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("rst_done");

        // Start held throughout, with a stray Ack while busy.
        start_op(32'd17, 32'd5);
        wait_done("held", 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("held_no_relaunch_done", 32'(dif.Done), 32'd1);
        check("held_no_relaunch_load", 32'(load_cnt - load_base), 32'd1);
        dif.Ack = 1'b1;
        @(posedge clk);
        #1;
        dif.Ack = 1'b0;
        check("held_ack_idle", 32'({dif.Done, dif.Busy, dif.Load}), 32'd0);
        push_exp(32'd17, 32'd5);
        snap_counts();
        wait_done("relaunch", 1'b1, 1'b0);
        ack_op("relaunch");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
